// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM/WB operand forwarding, load-use hazard
// detection (stall + bubble), branch flush and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd_addr,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [3:0]       id_alu_ctrl,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  ex_result,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd_addr,
    input  logic [XLEN-1:0]  mem_rd_data,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd_addr,
    input  logic [XLEN-1:0]  wb_rd_data,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_op_a,
    output logic [XLEN-1:0]  ex_op_b,
    output logic [4:0]       ex_rd_addr,
    output logic [3:0]       ex_alu_ctrl,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [XLEN-1:0] op_a_next;
    logic [XLEN-1:0] op_b_next;
    logic            hz;
    logic            bubble;

    // EX can only forward a non-load result; load data is not ready until MEM.
    logic ex_fwd_ok;
    assign ex_fwd_ok = ex_valid & ex_reg_write & ~ex_mem_read;

    // Operand source selection, youngest producer wins; x0 is always zero.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data
    );
        if (addr == 5'd0)
            fwd_sel = '0;
        else if (ex_fwd_ok && ex_rd_addr == addr)
            fwd_sel = ex_result;
        else if (mem_reg_write && mem_rd_addr == addr)
            fwd_sel = mem_rd_data;
        else if (wb_reg_write && wb_rd_addr == addr)
            fwd_sel = wb_rd_data;
        else
            fwd_sel = rf_data;
    endfunction

    // Forwarded operand values for the instruction currently in ID.
    always_comb begin
        op_a_next = fwd_sel(id_rs1_addr, rs1_data);
        op_b_next = fwd_sel(id_rs2_addr, rs2_data);
    end

    // Load-use hazard: a load in EX feeds a source the ID instruction really reads.
    always_comb begin
        hz = id_valid & ex_valid & ex_mem_read & (ex_rd_addr != 5'd0) &
             ((id_uses_rs1 & (ex_rd_addr == id_rs1_addr)) |
              (id_uses_rs2 & (ex_rd_addr == id_rs2_addr)));
        // A flush kills the ID instruction anyway, so holding it is pointless.
        stall  = hz & ~flush;
        bubble = flush | hz;
    end

    // Pipeline register: bubble on flush or hazard, otherwise capture ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_rd_addr   <= '0;
            ex_alu_ctrl  <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_alu_src   <= 1'b0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_rd_addr   <= '0;
            ex_alu_ctrl  <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_alu_src   <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_op_a      <= op_a_next;
            ex_op_b      <= op_b_next;
            ex_rd_addr   <= id_rd_addr;
            ex_alu_ctrl  <= id_alu_ctrl;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_mem_write <= id_mem_write;
            ex_alu_src   <= id_alu_src;
        end
    end

    // Count bubbles that displaced a real ID instruction, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= '0;
        else if (bubble && id_valid && bubble_cnt != {CNT_W{1'b1}})
            bubble_cnt <= bubble_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, x0, load-use,
// flush/hazard interaction, mid-stream reset and counter saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_uses_rs1, id_uses_rs2;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_ctrl;
    logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
    logic [31:0] rs1_data, rs2_data, ex_result;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        flush;
    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_op_a, ex_op_b;
    logic [4:0]  ex_rd_addr;
    logic [3:0]  ex_alu_ctrl;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [15:0] bubble_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd_addr(id_rd_addr), .id_imm(id_imm), .id_alu_ctrl(id_alu_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_result(ex_result),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_rd_addr(ex_rd_addr), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %-16s observed=0x%08h expected=0x%08h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v;  id_pc = pc;
        id_rs1_addr = rs1; id_uses_rs1 = u1;
        id_rs2_addr = rs2; id_uses_rs2 = u2;
        id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
        id_imm = 32'h0; id_alu_ctrl = 4'h0; id_mem_write = 1'b0; id_alu_src = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_id(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rs1_data = 32'h0; rs2_data = 32'h0; ex_result = 32'h0;
        mem_reg_write = 1'b0; mem_rd_addr = 5'd0; mem_rd_data = 32'h0;
        wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_rd_data = 32'h0;
        flush = 1'b0;

        // Reset asserted between edges takes effect immediately
        #2 rst_n = 1'b0;
        #1;
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_op_a", ex_op_a, 32'd0);
        check("rst_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", {31'd0, ex_valid}, 32'd0);

        // Capture I0: writes x5, check field capture
        @(negedge clk);
        set_id(1'b1, 32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        id_imm = 32'hFFFF_FFF0; id_alu_ctrl = 4'hA; id_mem_write = 1'b1; id_alu_src = 1'b1;
        tick();
        check("cap_valid", {31'd0, ex_valid}, 32'd1);
        check("cap_pc", ex_pc, 32'h100);
        check("cap_imm", ex_imm, 32'hFFFF_FFF0);
        check("cap_alu_ctrl", {28'd0, ex_alu_ctrl}, 32'hA);
        check("cap_rd", {27'd0, ex_rd_addr}, 32'd5);
        check("cap_mem_write", {31'd0, ex_mem_write}, 32'd1);
        check("cap_alu_src", {31'd0, ex_alu_src}, 32'd1);

        // EX, MEM and WB all write x5: EX wins (I1 writes x6)
        set_id(1'b1, 32'h104, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        ex_result = 32'h11;
        mem_reg_write = 1'b1; mem_rd_addr = 5'd5; mem_rd_data = 32'h22;
        wb_reg_write = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 32'h33;
        rs1_data = 32'h44; rs2_data = 32'h55;
        tick();
        check("fwd_ex_a", ex_op_a, 32'h11);
        check("fwd_ex_b", ex_op_b, 32'h11);

        // EX now writes x6 only: MEM wins
        set_id(1'b1, 32'h108, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        check("fwd_mem_a", ex_op_a, 32'h22);

        // Drop MEM writer: WB wins
        mem_reg_write = 1'b0;
        tick();
        check("fwd_wb_a", ex_op_a, 32'h33);

        // Drop WB writer: reg file data
        wb_reg_write = 1'b0;
        tick();
        check("fwd_rf_a", ex_op_a, 32'h44);
        check("fwd_rf_b", ex_op_b, 32'h55);

        // x0: EX instruction writes x0, ID reads x0
        set_id(1'b1, 32'h10C, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 32'h110, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
        ex_result = 32'hDEAD; rs1_data = 32'hBEEF;
        tick();
        check("x0_op_a", ex_op_a, 32'h0);

        // Load-use: lw x3 enters EX
        set_id(1'b1, 32'h114, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 32'h118, 5'd3, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);
        ex_result = 32'h99;
        #1;
        check("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        check("lu_bubble_op_a", ex_op_a, 32'd0);
        check("lu_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
        check("lu_stall_clear", {31'd0, stall}, 32'd0);
        // The load has moved to MEM; add is re-presented
        mem_reg_write = 1'b1; mem_rd_addr = 5'd3; mem_rd_data = 32'h77;
        tick();
        check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_add_op_a", ex_op_a, 32'h77);
        check("lu_add_pc", ex_pc, 32'h118);
        mem_reg_write = 1'b0;

        // No false stall on an unused rs2 that matches
        set_id(1'b1, 32'h11C, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 32'h120, 5'd7, 1'b1, 5'd3, 1'b0, 5'd8, 1'b1, 1'b0);
        #1;
        check("no_false_stall", {31'd0, stall}, 32'd0);
        id_uses_rs2 = 1'b1;
        #1;
        check("rs2_hazard_stall", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush_hz_stall", {31'd0, stall}, 32'd0);
        tick();
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_cnt", {16'd0, bubble_cnt}, 32'd2);
        // Flush with no real instruction in ID does not count
        id_valid = 1'b0;
        tick();
        check("flush_noid_cnt", {16'd0, bubble_cnt}, 32'd2);
        flush = 1'b0;

        // Mid-stream reset drops the EX instruction without a clock edge
        set_id(1'b1, 32'h200, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
        rs1_data = 32'h1234;
        tick();
        check("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        check("mid_rst_pc", ex_pc, 32'd0);
        check("mid_rst_cnt", {16'd0, bubble_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: 65535 counted flushes reach all-ones, then hold
        flush = 1'b1;
        id_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        check("sat_reach", {16'd0, bubble_cnt}, 32'hFFFF);
        tick();
        tick();
        check("sat_hold", {16'd0, bubble_cnt}, 32'hFFFF);
        flush = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
